// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input port: synchronised inputs, per-bit edge capture (W1C) and maskable level irq.
// Read data registered (1-cycle latency), irq combinational from flops; no backpressure, no wait states.
module pio_in_edge_irq #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [CW-1:0]    arm_cnt;
    logic             armed;
    logic             wr_en;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    // Upper writedata bits are don't-care for narrow instances.
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Hold off capture until the synchroniser and prev have flushed the reset zeros,
    // so inputs held high through reset do not look like rising edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else if (!armed) begin
            if (arm_cnt == CW'(SYNC_STAGES))
                armed <= 1'b1;
            else
                arm_cnt <= arm_cnt + CW'(1);
        end
    end

    always_comb begin
        rise = sync & ~prev;
        fall = ~sync & prev;
        case (EDGE_TYPE)
            0:       edge_hit = rise;
            1:       edge_hit = fall;
            default: edge_hit = rise | fall;
        endcase
        if (!armed)
            edge_hit = '0;
    end

    assign wr_en = chipselect & ~write_n;
    assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr_en && address == 2'd2)
                irq_mask <= writedata[WIDTH-1:0];
            // OR-ing the new edge after the clear makes a same-cycle edge win over W1C.
            edge_capture <= (edge_capture & ~clr) | edge_hit;
        end
    end

    assign irq = |(edge_capture & irq_mask);

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = sync;
            2'd2:    rd_next[WIDTH-1:0] = irq_mask;
            2'd3:    rd_next[WIDTH-1:0] = edge_capture;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd_next;
    end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: four instances (rise/fall/any edge, 4- and 32-bit) driven in lockstep
// and compared every cycle against a history-based reference model, plus directed scenario checks.
module tb_pio_in_edge_irq;

    localparam int N = 4;
    localparam int PW [N] = '{4, 4, 4, 32};
    localparam int PS [N] = '{2, 2, 3, 4};
    localparam int PE [N] = '{0, 1, 2, 0};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] tb_in [N];
    logic [31:0] rd0, rd1, rd2, rd3;
    logic        irq0, irq1, irq2, irq3;
    logic [3:0]  in0, in1, in2;
    logic [31:0] in3;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: sampled input history (index 0 = latest edge), capture, mask, read data.
    logic [31:0] m_hist [N][8];
    logic [31:0] m_cap  [N];
    logic [31:0] m_mask [N];
    logic [31:0] m_rd   [N];
    int          m_t;

    always #5 clk = ~clk;

    assign in0 = tb_in[0][3:0];
    assign in1 = tb_in[1][3:0];
    assign in2 = tb_in[2][3:0];
    assign in3 = tb_in[3];

    pio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));
    pio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));
    pio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(3), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));
    pio_in_edge_irq #(.WIDTH(32), .SYNC_STAGES(4), .EDGE_TYPE(0)) u_wide (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in3), .readdata(rd3), .irq(irq3));

    function automatic logic [31:0] wmask(int w);
        if (w >= 32)
            return 32'hFFFF_FFFF;
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] dut_rd(int i);
        case (i)
            0:       return rd0;
            1:       return rd1;
            2:       return rd2;
            default: return rd3;
        endcase
    endfunction

    function automatic logic dut_irq(int i);
        case (i)
            0:       return irq0;
            1:       return irq1;
            2:       return irq2;
            default: return irq3;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0;
        for (int i = 0; i < N; i++) begin
            m_cap[i]  = '0;
            m_mask[i] = '0;
            m_rd[i]   = '0;
            for (int k = 0; k < 8; k++)
                m_hist[i][k] = '0;
        end
    endtask

    // One rising edge: edge seen between the values sampled S and S+1 edges ago,
    // suppressed until S+1 edges have elapsed since reset release.
    task automatic model_edge();
        logic [31:0] s, p, det, ncap, nrd, wm;
        if (!reset_n)
            return;
        m_t++;
        for (int i = 0; i < N; i++) begin
            wm = wmask(PW[i]);
            s  = m_hist[i][PS[i]-1];
            p  = m_hist[i][PS[i]];
            case (PE[i])
                0:       det = s & ~p;
                1:       det = ~s & p;
                default: det = s ^ p;
            endcase
            det &= wm;
            if (m_t - 1 < PS[i] + 1)
                det = '0;
            case (address)
                2'd0:    nrd = s;
                2'd1:    nrd = '0;
                2'd2:    nrd = m_mask[i];
                default: nrd = m_cap[i];
            endcase
            ncap = m_cap[i];
            if (chipselect && !write_n && address == 2'd3)
                ncap &= ~writedata;
            m_cap[i] = (ncap | det) & wm;
            if (chipselect && !write_n && address == 2'd2)
                m_mask[i] = writedata & wm;
            m_rd[i] = nrd;
            for (int k = 7; k > 0; k--)
                m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = tb_in[i] & wm;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("readdata[%0d]", i), dut_rd(i), m_rd[i]);
            check_eq($sformatf("irq[%0d]", i), {31'b0, dut_irq(i)},
                     {31'b0, |(m_cap[i] & m_mask[i])});
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        tb_in[0]   = 32'hF;
        tb_in[1]   = 32'hF;
        tb_in[2]   = 32'hF;
        tb_in[3]   = 32'hFFFF_FFFF;
        model_reset();
        repeat (3) cycle();
        reset_n = 1'b1;

        // Inputs held high through reset must not be captured.
        address = 2'd3;
        repeat (10) cycle();
        check_eq("reset_hold_capture", rd0, 32'h0);
        check_eq("reset_hold_irq", {31'b0, irq0}, 32'h0);
        address = 2'd0;
        cycle();
        check_eq("reset_hold_data", rd0, 32'hF);

        // Rising-edge latency: capture and irq exactly SYNC_STAGES+1 edges after the change.
        bus_write(2'd2, 32'h1);
        tb_in[0] = 32'h0;
        repeat (5) cycle();
        address  = 2'd3;
        tb_in[0] = 32'h1;
        cycle();
        cycle();
        check_eq("latency_early_irq", {31'b0, irq0}, 32'h0);
        cycle();
        check_eq("latency_irq", {31'b0, irq0}, 32'h1);
        bus_write(2'd3, 32'h1);
        check_eq("w1c_irq_drop", {31'b0, irq0}, 32'h0);

        // Masked-out capture, then unmask raises irq right after the write edge.
        bus_write(2'd2, 32'h0);
        tb_in[0] = tb_in[0] | 32'h4;
        repeat (4) cycle();
        tb_in[0] = tb_in[0] & ~32'h4;
        repeat (4) cycle();
        address = 2'd3;
        cycle();
        check_eq("masked_capture", rd0, 32'h4);
        check_eq("masked_irq", {31'b0, irq0}, 32'h0);
        bus_write(2'd2, 32'h4);
        check_eq("unmask_irq", {31'b0, irq0}, 32'h1);

        // Falling-edge and any-edge instances on bit1.
        bus_write(2'd3, 32'hFFFF_FFFF);
        tb_in[1] = 32'hD;
        tb_in[2] = 32'hD;
        repeat (6) cycle();
        address = 2'd3;
        cycle();
        check_eq("fall_on_fall", rd1, 32'h2);
        check_eq("any_on_fall", rd2, 32'h2);
        bus_write(2'd3, 32'h2);
        tb_in[1] = 32'hF;
        tb_in[2] = 32'hF;
        repeat (6) cycle();
        address = 2'd3;
        cycle();
        check_eq("fall_on_rise", rd1, 32'h0);
        check_eq("any_on_rise", rd2, 32'h2);

        // W1C landing on the capture edge of bit3: the set wins.
        bus_write(2'd2, 32'h8);
        tb_in[0] = tb_in[0] | 32'h8;
        cycle();
        cycle();
        bus_write(2'd3, 32'h8);
        check_eq("set_wins_irq", {31'b0, irq0}, 32'h1);
        address = 2'd3;
        cycle();
        check_eq("set_wins_capture", rd0 & 32'h8, 32'h8);

        // Wide instance: data read, reserved address, ignored data write.
        tb_in[3] = 32'hA5A5_A5A5;
        repeat (8) cycle();
        address = 2'd0;
        cycle();
        check_eq("wide_data", rd3, 32'hA5A5_A5A5);
        address = 2'd1;
        cycle();
        check_eq("wide_reserved", rd3, 32'h0);
        bus_write(2'd0, 32'h0);
        address = 2'd0;
        cycle();
        check_eq("wide_data_after_write", rd3, 32'hA5A5_A5A5);

        // Random traffic with a mid-run asynchronous reset.
        for (int it = 0; it < 2400; it++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(5) == 0)
                    tb_in[i] = tb_in[i] ^ (32'd1 << $urandom_range(PW[i] - 1));
            chipselect = 1'($urandom_range(1));
            write_n    = ($urandom_range(3) != 0);
            address    = 2'($urandom_range(3));
            writedata  = $urandom;
            if (it == 1200) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                repeat (3) cycle();
                reset_n = 1'b1;
            end
            cycle();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
